// File: rtl/user_id_readout.sv
// Identification-word store with firmware override, sticky lock, parallel and bit-serial readback.
// Latency: parallel response 1 cycle after accept; serial bits start 1 cycle after accept, WORD_W cycles long.
// Backpressure: rd_ready_o low while a response or shift is in flight; requester must hold rd_valid_i.
module user_id_readout #(
    parameter int WORD_W = 32,
    parameter int N_WORDS = 4,
    parameter logic [N_WORDS*WORD_W-1:0] ID_VALUES = '0,
    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    output logic [N_WORDS*WORD_W-1:0] id_o,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    input  logic [IDX_W-1:0]          rd_idx_i,
    input  logic                      rd_serial_i,
    output logic                      resp_valid_o,
    output logic [WORD_W-1:0]         resp_data_o,
    output logic                      resp_err_o,
    output logic                      ser_o,
    output logic                      ser_valid_o,
    output logic                      ser_last_o,
    input  logic                      ovr_we_i,
    input  logic [IDX_W-1:0]          ovr_idx_i,
    input  logic [WORD_W-1:0]         ovr_data_i,
    input  logic                      lock_i,
    output logic                      locked_o
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_WORDS);

    typedef enum logic [1:0] {IDLE, RESP, SHIFT} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] shadow [N_WORDS];
    logic              locked;
    logic [WORD_W-1:0] snap, snap_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic              resp_valid_n, resp_err_n, ser_n, ser_valid_n, ser_last_n;
    logic [WORD_W-1:0] resp_data_n;
    logic [WORD_W-1:0] rd_word;
    logic              rd_in_range, wr_en;

    assign rd_in_range = ({1'b0, rd_idx_i} < N_LIM);
    // A lock arriving in the same cycle as a write takes priority.
    assign wr_en       = ovr_we_i && !locked && !lock_i && ({1'b0, ovr_idx_i} < N_LIM);
    assign rd_ready_o  = (state == IDLE);
    assign locked_o    = locked;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_word = shadow[i];
            end
        end
    end

    always_comb begin
        id_o = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            id_o[i*WORD_W +: WORD_W] = shadow[i];
        end
    end

    always_comb begin
        state_n      = state;
        snap_n       = snap;
        bit_cnt_n    = bit_cnt;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        resp_data_n  = '0;
        ser_n        = 1'b0;
        ser_valid_n  = 1'b0;
        ser_last_n   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_valid_i) begin
                    if (rd_serial_i && rd_in_range) begin
                        state_n     = SHIFT;
                        ser_n       = rd_word[WORD_W-1];
                        ser_valid_n = 1'b1;
                        snap_n      = rd_word << 1;
                        bit_cnt_n   = CNT_W'(1);
                    end else begin
                        // Out-of-range requests always answer in parallel form, even if serial.
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = !rd_in_range;
                        resp_data_n  = rd_in_range ? rd_word : '0;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            SHIFT: begin
                if (bit_cnt == CNT_W'(WORD_W)) begin
                    state_n = IDLE;
                end else begin
                    ser_n        = snap[WORD_W-1];
                    ser_valid_n  = 1'b1;
                    snap_n       = snap << 1;
                    bit_cnt_n    = bit_cnt + 1'b1;
                    ser_last_n   = (bit_cnt == CNT_W'(WORD_W-1));
                    resp_valid_n = ser_last_n;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            locked       <= 1'b0;
            snap         <= '0;
            bit_cnt      <= '0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_data_o  <= '0;
            ser_o        <= 1'b0;
            ser_valid_o  <= 1'b0;
            ser_last_o   <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) begin
                shadow[i] <= ID_VALUES[i*WORD_W +: WORD_W];
            end
        end else begin
            state        <= state_n;
            snap         <= snap_n;
            bit_cnt      <= bit_cnt_n;
            resp_valid_o <= resp_valid_n;
            resp_err_o   <= resp_err_n;
            resp_data_o  <= resp_data_n;
            ser_o        <= ser_n;
            ser_valid_o  <= ser_valid_n;
            ser_last_o   <= ser_last_n;
            if (lock_i) begin
                locked <= 1'b1;
            end
            for (int i = 0; i < N_WORDS; i++) begin
                if (wr_en && ovr_idx_i == IDX_W'(i)) begin
                    shadow[i] <= ovr_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_user_id_readout.sv
// Bench for user_id_readout: reset values, table of reads, override/lock/snapshot
// sequences, out-of-range on a 3-word instance, mid-shift reset and randomized traffic.
module tb_user_id_readout;

    localparam logic [127:0] ID4 = {32'hDEADBEEF, 32'h12345678, 32'hA5A50F0F, 32'h00000001};
    localparam logic [95:0]  ID3 = ID4[95:0];

    logic         clk = 1'b0;
    logic         wb_rst;
    logic [127:0] id;
    logic         rd_valid, rd_ready, rd_serial;
    logic [1:0]   rd_idx;
    logic         resp_valid, resp_err, ser, ser_valid, ser_last;
    logic [31:0]  resp_data;
    logic         ovr_we, lock, locked;
    logic [1:0]   ovr_idx;
    logic [31:0]  ovr_data;

    logic [95:0]  b_id;
    logic         b_rd_valid, b_rd_ready, b_rd_serial;
    logic [1:0]   b_rd_idx;
    logic         b_resp_valid, b_resp_err, b_ser, b_ser_valid, b_ser_last;
    logic [31:0]  b_resp_data;
    logic         b_ovr_we, b_lock, b_locked;
    logic [1:0]   b_ovr_idx;
    logic [31:0]  b_ovr_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_sh [4];
    bit          m_locked;

    always #5 clk = ~clk;

    user_id_readout #(.WORD_W(32), .N_WORDS(4), .ID_VALUES(ID4)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst), .id_o(id),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_idx_i(rd_idx), .rd_serial_i(rd_serial),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_err_o(resp_err),
        .ser_o(ser), .ser_valid_o(ser_valid), .ser_last_o(ser_last),
        .ovr_we_i(ovr_we), .ovr_idx_i(ovr_idx), .ovr_data_i(ovr_data),
        .lock_i(lock), .locked_o(locked)
    );

    user_id_readout #(.WORD_W(32), .N_WORDS(3), .ID_VALUES(ID3)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(wb_rst), .id_o(b_id),
        .rd_valid_i(b_rd_valid), .rd_ready_o(b_rd_ready), .rd_idx_i(b_rd_idx), .rd_serial_i(b_rd_serial),
        .resp_valid_o(b_resp_valid), .resp_data_o(b_resp_data), .resp_err_o(b_resp_err),
        .ser_o(b_ser), .ser_valid_o(b_ser_valid), .ser_last_o(b_ser_last),
        .ovr_we_i(b_ovr_we), .ovr_idx_i(b_ovr_idx), .ovr_data_i(b_ovr_data),
        .lock_i(b_lock), .locked_o(b_locked)
    );

    typedef struct {
        int          idx;
        bit          serial;
        logic [31:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model_id();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = m_sh[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = ID4[i*32 +: 32];
        m_locked = 0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] data, input bit lk);
        if (!m_locked && !lk) m_sh[idx] = data;
        if (lk) m_locked = 1;
    endtask

    task automatic write_a(input string nm, input int idx, input logic [31:0] data, input bit lk);
        ovr_we = 1; ovr_idx = 2'(idx); ovr_data = data; lock = lk;
        step();
        ovr_we = 0; lock = 0;
        model_write(idx, data, lk);
        chk({nm, "_id"}, id, model_id());
        chk({nm, "_locked"}, locked, m_locked);
    endtask

    // Full read on the 4-word instance; optional write held for the accept cycle and the next.
    task automatic read_a(input string nm, input int idx, input bit serial, input logic [31:0] exp,
                          input bit do_wr, input int wr_idx, input logic [31:0] wr_data);
        logic [31:0] word;
        int          nbits;
        bit          bad, got_last;
        chk({nm, "_ready_pre"}, rd_ready, 1);
        rd_valid = 1; rd_idx = 2'(idx); rd_serial = serial;
        if (do_wr) begin
            ovr_we = 1; ovr_idx = 2'(wr_idx); ovr_data = wr_data;
        end
        step();
        rd_valid = 0;
        if (do_wr) model_write(wr_idx, wr_data, 0);
        if (!serial) begin
            chk({nm, "_rvalid"}, resp_valid, 1);
            chk({nm, "_rdata"}, resp_data, exp);
            chk({nm, "_rerr"}, resp_err, 0);
            chk({nm, "_ready_busy"}, rd_ready, 0);
            step();
            ovr_we = 0;
            chk({nm, "_rvalid_end"}, resp_valid, 0);
            chk({nm, "_ready_post"}, rd_ready, 1);
        end else begin
            word = 0; nbits = 0; bad = 0; got_last = 0;
            for (int c = 0; c < 40 && !got_last; c++) begin
                if (ser_valid) begin
                    word = {word[30:0], ser};
                    nbits++;
                end else begin
                    bad = 1;
                end
                if (rd_ready || resp_err || resp_data !== 0) bad = 1;
                if (resp_valid !== ser_last) bad = 1;
                if (ser_last) begin
                    got_last = 1;
                end else begin
                    step();
                    if (c == 0) ovr_we = 0;
                end
            end
            ovr_we = 0;
            chk({nm, "_sword"}, word, exp);
            chk({nm, "_sbits"}, nbits, 32);
            chk({nm, "_sproto"}, bad, 0);
            chk({nm, "_slast"}, got_last, 1);
            step();
            chk({nm, "_svalid_end"}, ser_valid, 0);
            chk({nm, "_ready_post"}, rd_ready, 1);
            chk({nm, "_rvalid_end"}, resp_valid, 0);
        end
    endtask

    initial begin
        vec_t vt[8];
        bit   b_ser_seen;
        int   idx;

        vt[0] = '{2, 0, 32'h12345678};
        vt[1] = '{0, 0, 32'h00000001};
        vt[2] = '{1, 0, 32'hA5A50F0F};
        vt[3] = '{3, 0, 32'hDEADBEEF};
        vt[4] = '{3, 1, 32'hDEADBEEF};
        vt[5] = '{0, 1, 32'h00000001};
        vt[6] = '{1, 1, 32'hA5A50F0F};
        vt[7] = '{2, 1, 32'h12345678};

        wb_rst = 1; rd_valid = 0; rd_idx = 0; rd_serial = 0;
        ovr_we = 0; ovr_idx = 0; ovr_data = 0; lock = 0;
        b_rd_valid = 0; b_rd_idx = 0; b_rd_serial = 0;
        b_ovr_we = 0; b_ovr_idx = 0; b_ovr_data = 0; b_lock = 0;
        model_reset();
        step();
        step();
        chk("rst_id", id, ID4);
        chk("rst_locked", locked, 0);
        chk("rst_ready", rd_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rerr", resp_err, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_ser", {ser, ser_valid, ser_last}, 3'b000);
        wb_rst = 0;
        step();

        for (int i = 0; i < 8; i++) begin
            read_a($sformatf("vec%0d", i), vt[i].idx, vt[i].serial, vt[i].exp, 0, 0, 0);
        end

        write_a("ovr0", 0, 32'hCAFEF00D, 0);
        chk("ovr0_low", id[31:0], 32'hCAFEF00D);
        read_a("ovr0_rd", 0, 0, 32'hCAFEF00D, 0, 0, 0);

        read_a("snap_par", 2, 0, 32'h12345678, 1, 2, 32'h0BADF00D);
        read_a("snap_par2", 2, 0, 32'h0BADF00D, 0, 0, 0);
        read_a("snap_ser", 1, 1, 32'hA5A50F0F, 1, 1, 32'h55AA55AA);
        read_a("snap_ser2", 1, 1, 32'h55AA55AA, 0, 0, 0);
        write_a("restore1", 1, 32'hA5A50F0F, 0);

        write_a("lock_wr", 1, 32'hFFFFFFFF, 1);
        chk("lock_set", locked, 1);
        read_a("lock_rd", 1, 0, 32'hA5A50F0F, 0, 0, 0);
        write_a("locked_wr", 3, 32'h00000000, 0);
        read_a("locked_rd", 3, 1, 32'hDEADBEEF, 0, 0, 0);

        b_rd_valid = 1; b_rd_idx = 2'd3; b_rd_serial = 1;
        step();
        b_rd_valid = 0;
        chk("oor_rvalid", b_resp_valid, 1);
        chk("oor_rerr", b_resp_err, 1);
        chk("oor_rdata", b_resp_data, 0);
        b_ser_seen = b_ser_valid;
        for (int c = 0; c < 6; c++) begin
            step();
            if (b_ser_valid) b_ser_seen = 1;
        end
        chk("oor_noser", b_ser_seen, 0);
        chk("oor_ready", b_rd_ready, 1);

        rd_valid = 1; rd_idx = 2'd3; rd_serial = 1;
        step();
        rd_valid = 0;
        for (int c = 1; c < 10; c++) step();
        chk("mid_shift_active", ser_valid, 1);
        wb_rst = 1;
        step();
        wb_rst = 0;
        chk("mrst_sv", ser_valid, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_id", id, ID4);
        chk("mrst_ready", rd_ready, 1);
        chk("mrst_rvalid", resp_valid, 0);
        model_reset();
        step();

        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 3) begin
                write_a("rnd_wr", idx, $urandom, $urandom_range(0, 39) == 0);
            end else begin
                read_a("rnd_rd", idx, 1'($urandom_range(0, 1)), m_sh[idx],
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom);
            end
        end
        chk("rnd_final_id", id, model_id());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
